// File: rtl/cc_coef_bank_csr.sv
// cc_coef_bank_csr: AXI4-Lite CSR block for the colour corrector.
// Double-buffered coefficient bank, committed on start-of-frame or at once.
module cc_coef_bank_csr #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          ADDR_W        = 32,
  parameter int          COEF_CNT      = 12,
  parameter int          COEF_W        = 32,
  parameter bit          COMMIT_ON_SOF = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       awvalid_i,
  output logic                       awready_o,
  input  logic [ADDR_W-1:0]          awaddr_i,
  input  logic                       wvalid_i,
  output logic                       wready_o,
  input  logic [31:0]                wdata_i,
  input  logic [3:0]                 wstrb_i,
  output logic                       bvalid_o,
  input  logic                       bready_i,
  output logic [1:0]                 bresp_o,
  input  logic                       arvalid_i,
  output logic                       arready_o,
  input  logic [ADDR_W-1:0]          araddr_i,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  output logic [31:0]                rdata_o,
  output logic [1:0]                 rresp_o,
  input  logic                       sof_i,
  output logic [COEF_CNT*COEF_W-1:0] coef_o,
  output logic                       coef_upd_o
);

  localparam int SW = $clog2(COEF_CNT);
  localparam logic [SW:0]   CNT_X = (SW+1)'(COEF_CNT);
  localparam logic [SW-1:0] LAST  = SW'(COEF_CNT - 1);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_SEL  = 3'd1;
  localparam logic [2:0] A_COEF = 3'd2;
  localparam logic [2:0] A_STAT = 3'd3;
  localparam logic [2:0] A_ACT  = 3'd4;

  logic              r_aw_held;
  logic [ADDR_W-1:0] r_aw_addr;
  logic              r_w_held;
  logic [31:0]       r_w_data;
  logic [3:0]        r_w_strb;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_rvalid;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic              r_auto;
  logic              r_pend;
  logic              r_upd;
  logic [SW-1:0]     r_sel;
  logic [7:0]        r_cnt;
  logic [COEF_W-1:0] r_shadow [COEF_CNT];
  logic [COEF_W-1:0] r_active [COEF_CNT];

  logic              w_sel_ok;
  logic [SW-1:0]     w_sel_idx;
  logic [31:0]       w_sh_ext;
  logic [31:0]       w_act_ext;
  logic [31:0]       w_mask;
  logic [31:0]       w_merged;
  logic [3:0]        w_wdec;
  logic [3:0]        w_rdec;
  logic              w_wr_go;
  logic              w_w_ctrl;
  logic              w_w_sel;
  logic              w_w_coef;
  logic              w_wr_err;
  logic              w_do_ctrl;
  logic              w_do_sel;
  logic              w_do_coef;
  logic              w_req;
  logic              w_commit;
  logic              w_rd_go;
  logic              w_rerr;
  logic [31:0]       w_rdata;

  // {mapped, idx}; addresses below BASE wrap to a huge offset
  function automatic logic [3:0] f_dec(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - ADDR_W'(BASE_ADDR);
    f_dec = {1'b0, off[4:2]};
    if (off[ADDR_W-1:5] == '0 && off[4:2] <= A_ACT)
      f_dec[3] = 1'b1;
  endfunction

  assign w_sel_ok  = {1'b0, r_sel} < CNT_X;
  assign w_sel_idx = w_sel_ok ? r_sel : '0;

  always_comb begin
    w_sh_ext  = '0;
    w_act_ext = '0;
    w_sh_ext[COEF_W-1:0]  = r_shadow[w_sel_idx];
    w_act_ext[COEF_W-1:0] = r_active[w_sel_idx];
  end

  assign w_mask = {{8{r_w_strb[3]}}, {8{r_w_strb[2]}},
                   {8{r_w_strb[1]}}, {8{r_w_strb[0]}}};
  assign w_merged = (w_sh_ext & ~w_mask) | (r_w_data & w_mask);

  assign w_wdec   = f_dec(r_aw_addr);
  assign w_wr_go  = r_aw_held & r_w_held & ~r_bvalid;
  assign w_w_ctrl = w_wdec[3] && (w_wdec[2:0] == A_CTRL);
  assign w_w_sel  = w_wdec[3] && (w_wdec[2:0] == A_SEL);
  assign w_w_coef = w_wdec[3] && (w_wdec[2:0] == A_COEF);
  assign w_wr_err = !(w_w_ctrl || w_w_sel || (w_w_coef && w_sel_ok));

  assign w_do_ctrl = w_wr_go & w_w_ctrl;
  assign w_do_sel  = w_wr_go & w_w_sel;
  assign w_do_coef = w_wr_go & w_w_coef & w_sel_ok;
  assign w_req     = w_do_ctrl & r_w_strb[0] & r_w_data[1];
  assign w_commit  = r_pend & (COMMIT_ON_SOF ? sof_i : 1'b1);

  assign w_rdec  = f_dec(araddr_i);
  assign w_rd_go = arvalid_i & ~r_rvalid;

  always_comb begin
    w_rdata = '0;
    w_rerr  = 1'b1;
    if (w_rdec[3]) begin
      unique case (w_rdec[2:0])
        A_CTRL: begin
          w_rdata[1:0] = {r_pend, r_auto};
          w_rerr = 1'b0;
        end
        A_SEL: begin
          w_rdata[SW-1:0] = r_sel;
          w_rerr = 1'b0;
        end
        A_COEF: if (w_sel_ok) begin
          w_rdata = w_sh_ext;
          w_rerr = 1'b0;
        end
        A_STAT: begin
          w_rdata = {8'h00, r_cnt, 8'(COEF_CNT), 7'h00, r_pend};
          w_rerr = 1'b0;
        end
        A_ACT: if (w_sel_ok) begin
          w_rdata = w_act_ext;
          w_rerr = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      if (awvalid_i && !r_aw_held) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= awaddr_i;
      end else if (w_wr_go) begin
        r_aw_held <= 1'b0;
      end
      if (wvalid_i && !r_w_held) begin
        r_w_held <= 1'b1;
        r_w_data <= wdata_i;
        r_w_strb <= wstrb_i;
      end else if (w_wr_go) begin
        r_w_held <= 1'b0;
      end
      if (w_wr_go) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? SLVERR : OKAY;
      end else if (bready_i) begin
        r_bvalid <= 1'b0;
        r_bresp  <= OKAY;
      end
      if (w_rd_go) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
        r_rresp  <= w_rerr ? SLVERR : OKAY;
      end else if (r_rvalid && rready_i) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
        r_rresp  <= OKAY;
      end
    end
  end

  // Nonblocking copy: a same-edge COEF write lands only in the shadow
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < COEF_CNT; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
      r_auto <= 1'b0;
      r_sel  <= '0;
      r_pend <= 1'b0;
      r_cnt  <= '0;
      r_upd  <= 1'b0;
    end else begin
      if (w_do_coef)
        r_shadow[w_sel_idx] <= w_merged[COEF_W-1:0];
      if (w_commit)
        for (int k = 0; k < COEF_CNT; k++)
          r_active[k] <= r_shadow[k];
      if (w_do_ctrl && r_w_strb[0])
        r_auto <= r_w_data[0];
      if (w_do_sel && r_w_strb[0])
        r_sel <= r_w_data[SW-1:0];
      else if (w_do_coef && r_auto)
        r_sel <= (r_sel == LAST) ? '0 : r_sel + 1'b1;
      r_pend <= w_req | (r_pend & ~w_commit);
      if (w_commit)
        r_cnt <= r_cnt + 8'd1;
      r_upd <= w_commit;
    end
  end

  for (genvar k = 0; k < COEF_CNT; k++) begin : g_pack
    assign coef_o[k*COEF_W +: COEF_W] = r_active[k];
  end

  assign awready_o  = ~r_aw_held;
  assign wready_o   = ~r_w_held;
  assign bvalid_o   = r_bvalid;
  assign bresp_o    = r_bresp;
  assign arready_o  = ~r_rvalid;
  assign rvalid_o   = r_rvalid;
  assign rdata_o    = r_rdata;
  assign rresp_o    = r_rresp;
  assign coef_upd_o = r_upd;

endmodule

// File: tb/tb_cc_coef_bank_csr.sv
// tb_cc_coef_bank_csr: vector table, timing sequences and random ops
// against a reference model of the coefficient bank CSR.
module tb_cc_coef_bank_csr;
  localparam int N = 12;
  localparam int W = 32;
  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_SEL  = 32'h4;
  localparam logic [31:0] A_COEF = 32'h8;
  localparam logic [31:0] A_STAT = 32'hC;
  localparam logic [31:0] A_ACT  = 32'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, sof = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid, upd;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [N*W-1:0] coef;
  logic awready0, wready0, bvalid0, arready0, rvalid0, upd0;
  logic [1:0] bresp0, rresp0;
  logic [31:0] rdata0;
  logic [N*W-1:0] coef0;

  always #5 clk = ~clk;

  cc_coef_bank_csr #(.COMMIT_ON_SOF(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
    .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
    .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
    .sof_i(sof), .coef_o(coef), .coef_upd_o(upd));

  cc_coef_bank_csr #(.COMMIT_ON_SOF(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .awvalid_i(awvalid), .awready_o(awready0), .awaddr_i(awaddr),
    .wvalid_i(wvalid), .wready_o(wready0), .wdata_i(wdata), .wstrb_i(wstrb),
    .bvalid_o(bvalid0), .bready_i(bready), .bresp_o(bresp0),
    .arvalid_i(arvalid), .arready_o(arready0), .araddr_i(araddr),
    .rvalid_o(rvalid0), .rready_i(rready), .rdata_o(rdata0), .rresp_o(rresp0),
    .sof_i(sof), .coef_o(coef0), .coef_upd_o(upd0));

  int n_chk = 0;
  int n_fail = 0;
  int upd1_cnt = 0;
  int upd0_cnt = 0;

  always @(posedge clk) begin
    if (upd === 1'b1) upd1_cnt <= upd1_cnt + 1;
    if (upd0 === 1'b1) upd0_cnt <= upd0_cnt + 1;
  end

  // reference model
  logic [31:0] m_sh [N];
  logic [31:0] m_act [N];
  logic [31:0] m_act0 [N];
  int m_sel, m_cnt, m_ncommit, m_ncommit0;
  bit m_auto, m_pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < N; k++) begin
      m_sh[k] = 0; m_act[k] = 0; m_act0[k] = 0;
    end
    m_sel = 0; m_cnt = 0; m_auto = 0; m_pend = 0;
  endtask

  task automatic m_commit();
    m_act = m_sh;
    m_pend = 0;
    m_cnt = (m_cnt + 1) % 256;
    m_ncommit++;
  endtask

  task automatic m_write(input logic [31:0] a, d, input logic [3:0] s,
                         input bit sof_ex, output logic [1:0] r);
    if (sof_ex && m_pend) m_commit();
    r = 2'b10;
    if (a < 20) begin
      case (a / 4)
        0: begin
          r = 2'b00;
          if (s[0]) begin
            m_auto = d[0];
            if (d[1]) begin
              m_pend = 1;
              m_act0 = m_sh;
              m_ncommit0++;
            end
          end
        end
        1: begin
          r = 2'b00;
          if (s[0]) m_sel = d % 16;
        end
        2: if (m_sel < N) begin
          r = 2'b00;
          for (int b = 0; b < 4; b++)
            if (s[b]) m_sh[m_sel][8*b +: 8] = d[8*b +: 8];
          if (m_auto) m_sel = (m_sel + 1) % N;
        end
        default: ;
      endcase
    end
  endtask

  task automatic m_read(input logic [31:0] a, output logic [31:0] d,
                        output logic [1:0] r);
    d = 0; r = 2'b10;
    if (a < 20) begin
      case (a / 4)
        0: begin d = 2 * m_pend + m_auto; r = 0; end
        1: begin d = m_sel; r = 0; end
        2: if (m_sel < N) begin d = m_sh[m_sel]; r = 0; end
        3: begin d = m_cnt * 65536 + N * 256 + m_pend; r = 0; end
        4: if (m_sel < N) begin d = m_act[m_sel]; r = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic axi_write(input logic [31:0] a, d, input logic [3:0] s,
                           input bit sof_ex, output logic [1:0] r);
    int t;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1; bready = 1; r = 2'b11; t = 0;
    while ((awvalid || wvalid) && t < 50) begin
      bit fa, fw;
      fa = awvalid && awready;
      fw = wvalid && wready;
      @(posedge clk); #1;
      if (fa) awvalid = 0;
      if (fw) wvalid = 0;
      t++;
    end
    if (sof_ex) begin
      sof = 1; @(posedge clk); #1; sof = 0;
    end
    while (!bvalid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL write_timeout: addr 0x%08h got no response, required one", a);
      awvalid = 0; wvalid = 0; bready = 0;
      return;
    end
    r = bresp;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] r);
    int t;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1; t = 0;
    d = 32'hDEAD_BEEF; r = 2'b11;
    while (arvalid && t < 50) begin
      bit f;
      f = arvalid && arready;
      @(posedge clk); #1;
      if (f) arvalid = 0;
      t++;
    end
    if (!rvalid) begin
      n_chk++; n_fail++;
      $display("FAIL read_valid: addr 0x%08h rvalid 0, required 1", a);
      arvalid = 0; rready = 0;
      return;
    end
    d = rdata; r = rresp;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic check_coef(input string nm);
    for (int k = 0; k < N; k++) begin
      chk({nm, "_coef"}, coef[k*W +: W], m_act[k]);
      chk({nm, "_coef0"}, coef0[k*W +: W], m_act0[k]);
    end
  endtask

  task automatic do_w(input string nm, input logic [31:0] a, d,
                      input logic [3:0] s, input bit sof_ex);
    logic [1:0] r, er;
    axi_write(a, d, s, sof_ex, r);
    m_write(a, d, s, sof_ex, er);
    chk({nm, "_bresp"}, 32'(r), 32'(er));
    check_coef(nm);
  endtask

  task automatic do_r(input string nm, input logic [31:0] a);
    logic [31:0] d, ed;
    logic [1:0] r, er;
    axi_read(a, d, r);
    m_read(a, ed, er);
    chk({nm, "_rdata"}, d, ed);
    chk({nm, "_rresp"}, 32'(r), 32'(er));
  endtask

  task automatic pulse_sof();
    @(negedge clk); sof = 1;
    @(negedge clk); sof = 0;
    if (m_pend) m_commit();
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit wr, input logic [31:0] a, d, input logic [3:0] s,
                     input logic [31:0] ed, input logic [1:0] er, input string nm);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s;
    v.exp_d = ed; v.exp_r = er; v.nm = nm;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0] r, er;
    int b1, b0;

    m_reset();
    m_ncommit = 0; m_ncommit0 = 0;
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(awready), 1);
    chk("rst_wready", 32'(wready), 1);
    chk("rst_arready", 32'(arready), 1);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_upd", 32'(upd), 0);
    check_coef("rst");
    rst = 0;

    add(0, A_CTRL, 0, 0, 32'h0, 2'b00, "ctrl_rst");
    add(0, A_STAT, 0, 0, 32'h0000_0C00, 2'b00, "stat_rst");
    add(0, A_SEL, 0, 0, 32'h0, 2'b00, "sel_rst");
    add(1, 32'h40, 32'h1, 4'hF, 0, 2'b10, "wr_unmapped");
    add(0, 32'h40, 0, 0, 32'h0, 2'b10, "rd_unmapped");
    add(1, A_SEL, 32'd12, 4'hF, 0, 2'b00, "sel_12");
    add(0, A_SEL, 0, 0, 32'd12, 2'b00, "sel_rd12");
    add(0, A_COEF, 0, 0, 32'h0, 2'b10, "coef_rd_oob");
    add(1, A_COEF, 32'h1234, 4'hF, 0, 2'b10, "coef_wr_oob");
    add(0, A_ACT, 0, 0, 32'h0, 2'b10, "act_rd_oob");
    add(1, A_STAT, 32'hFFFF_FFFF, 4'hF, 0, 2'b10, "stat_wr");
    add(0, A_STAT, 0, 0, 32'h0000_0C00, 2'b00, "stat_keep");
    add(1, A_ACT, 32'h5, 4'hF, 0, 2'b10, "act_wr");
    add(1, A_SEL, 32'd3, 4'hF, 0, 2'b00, "sel_3");
    add(1, A_COEF, 32'h1111_1111, 4'hF, 0, 2'b00, "coef_full");
    add(1, A_COEF, 32'hAABB_CCDD, 4'b0101, 0, 2'b00, "coef_strb");
    add(0, A_COEF, 0, 0, 32'h11BB_11DD, 2'b00, "coef_merged");
    add(0, A_ACT, 0, 0, 32'h0, 2'b00, "act_precommit");
    add(0, 32'h0B, 0, 0, 32'h11BB_11DD, 2'b00, "coef_lowbits");
    add(0, 32'h14, 0, 0, 32'h0, 2'b10, "rd_idx5");
    add(0, 32'hFFFF_FFFC, 0, 0, 32'h0, 2'b10, "rd_wrap");
    add(1, A_SEL, 32'h7, 4'h0, 0, 2'b00, "sel_nostrb");
    add(0, A_SEL, 0, 0, 32'd3, 2'b00, "sel_unchanged");

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, r);
        m_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, er);
        chk({tbl[i].nm, "_bresp"}, 32'(r), 32'(tbl[i].exp_r));
      end else begin
        axi_read(tbl[i].addr, d, r);
        chk({tbl[i].nm, "_rdata"}, d, tbl[i].exp_d);
        chk({tbl[i].nm, "_rresp"}, 32'(r), 32'(tbl[i].exp_r));
        chk({tbl[i].nm, "_rdata_idle"}, rdata, 0);
      end
    end
    check_coef("tbl");

    // full bank load with auto-increment, then SOF commit
    do_w("auto_on", A_CTRL, 32'h1, 4'h1, 0);
    do_w("sel_0", A_SEL, 32'h0, 4'hF, 0);
    for (int k = 0; k < N; k++)
      do_w("load", A_COEF, 32'h100 + k, 4'hF, 0);
    do_r("sel_wrapped", A_SEL);
    b1 = upd1_cnt; b0 = upd0_cnt;
    do_w("commit_req", A_CTRL, 32'h3, 4'h1, 0);
    do_r("stat_pending", A_STAT);
    repeat (2) @(negedge clk);
    chk("upd0_pulse", 32'(upd0_cnt - b0), 1);
    chk("upd1_wait", 32'(upd1_cnt - b1), 0);
    check_coef("pre_sof");
    pulse_sof();
    repeat (2) @(negedge clk);
    chk("upd1_pulse", 32'(upd1_cnt - b1), 1);
    check_coef("post_sof");
    axi_read(A_STAT, d, r);
    chk("stat_commit1", d, 32'h0001_0C00);
    chk("coef_k5", coef[5*W +: W], 32'h105);

    // request coincident with SOF waits for the next SOF
    do_w("sel_b0", A_SEL, 32'h0, 4'hF, 0);
    do_w("coef_b0", A_COEF, 32'h5555, 4'hF, 0);
    b1 = upd1_cnt;
    do_w("req_at_sof", A_CTRL, 32'h3, 4'h1, 1);
    repeat (2) @(negedge clk);
    chk("upd_req_at_sof", 32'(upd1_cnt - b1), 0);
    do_r("stat_req_sof", A_STAT);
    do_w("sel_b1", A_SEL, 32'h0, 4'hF, 0);
    do_w("coef_at_commit", A_COEF, 32'hDEAD_0000, 4'hF, 1);
    chk("act0_prewrite", coef[W-1:0], 32'h5555);
    do_w("sel_b2", A_SEL, 32'h0, 4'hF, 0);
    do_r("shadow_new", A_COEF);
    do_r("active_old", A_ACT);
    do_r("stat_commit2", A_STAT);

    // SOF without a pending request
    b1 = upd1_cnt;
    pulse_sof();
    repeat (2) @(negedge clk);
    chk("sof_idle_upd", 32'(upd1_cnt - b1), 0);
    do_r("sof_idle_stat", A_STAT);

    // AW early, W five cycles later; B back-pressure stalls a second AW
    @(negedge clk);
    awaddr = A_SEL; wdata = 32'd5; wstrb = 4'hF; awvalid = 1; bready = 0;
    @(posedge clk); #1;
    awvalid = 0;
    for (int c = 1; c <= 4; c++) begin
      chk("aw_held_low", 32'(awready), 0);
      @(posedge clk); #1;
    end
    chk("aw_held_low5", 32'(awready), 0);
    wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0;
    chk("b_not_yet", 32'(bvalid), 0);
    @(posedge clk); #1;
    chk("b_at_6", 32'(bvalid), 1);
    chk("aw_free_6", 32'(awready), 1);
    awaddr = A_SEL; wdata = 32'd7; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    for (int c = 0; c < 4; c++) begin
      chk("b_hold", 32'(bvalid), 1);
      chk("aw2_stall", 32'(awready), 0);
      @(posedge clk); #1;
    end
    bready = 1;
    @(posedge clk); #1;
    chk("b_drop", 32'(bvalid), 0);
    @(posedge clk); #1;
    chk("b2_valid", 32'(bvalid), 1);
    chk("b2_resp", 32'(bresp), 0);
    @(posedge clk); #1;
    bready = 0;
    m_write(A_SEL, 32'd5, 4'hF, 0, er);
    m_write(A_SEL, 32'd7, 4'hF, 0, er);
    do_r("sel_after_stall", A_SEL);

    // commit counter wraps after 256 commits
    b1 = upd1_cnt;
    for (int i = 0; i < 300 && m_cnt != 0; i++) begin
      do_w("wrap_req", A_CTRL, 32'h3, 4'h1, 0);
      pulse_sof();
    end
    axi_read(A_STAT, d, r);
    chk("cnt_wrap", d[23:16], 0);
    repeat (2) @(negedge clk);
    chk("wrap_upds", 32'(upd1_cnt - b1), 254);

    // randomized operations
    for (int i = 0; i < 300; i++) begin
      int op;
      op = $urandom_range(0, 6);
      case (op)
        0: do_w("rnd_sel", A_SEL, $urandom_range(0, 13), 4'hF, 0);
        1, 2: do_w("rnd_coef", A_COEF, $urandom, 4'($urandom_range(0, 15)), 0);
        3: do_w("rnd_ctrl", A_CTRL,
                {30'h0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))},
                4'h1, 0);
        4: do_r("rnd_rd", 4 * $urandom_range(0, 5) + $urandom_range(0, 3));
        5: begin pulse_sof(); check_coef("rnd_sof"); end
        default: do_r("rnd_coef_rd", A_COEF);
      endcase
    end

    // reset with a pending commit and a half-finished write
    do_w("rst_req", A_CTRL, 32'h3, 4'h1, 0);
    do_r("rst_req_stat", A_STAT);
    @(negedge clk);
    awaddr = A_COEF; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    chk("aw_held_pre_rst", 32'(awready), 0);
    rst = 1;
    #1;
    m_reset();
    chk("rst_async_aw", 32'(awready), 1);
    chk("rst_async_b", 32'(bvalid), 0);
    check_coef("rst_mid");
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    wdata = 32'h1; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    repeat (3) @(negedge clk);
    chk("no_b_after_rst", 32'(bvalid), 0);
    chk("upd_after_rst", 32'(upd), 0);
    do_r("stat_after_rst", A_STAT);
    chk("upd1_total", 32'(upd1_cnt), 32'(m_ncommit));
    chk("upd0_total", 32'(upd0_cnt), 32'(m_ncommit0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cc_coef_bank_csr.md
Name: cc_coef_bank_csr

Overview:
- AXI4-Lite CSR block for the colour corrector, generalised from a fixed three-register file to a COEF_CNT-deep, COEF_W-wide coefficient bank.
- Bank is double-buffered: software writes shadow entries through a select/data window, then requests a commit.
- Commit copies all shadow entries atomically to the active bank, either on the next start-of-frame or immediately.
- Active bank drives the colour-correction datapath as a flat vector.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of the register window
ADDR_W, 32, AXI address width
COEF_CNT, 12, number of coefficients (2..255)
COEF_W, 32, coefficient width (1..32), right-aligned in rdata/wdata
COMMIT_ON_SOF, 1, 1: commit waits for sof_i; 0: commit on the cycle after the request

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
awvalid_i/awready_o  in/out  1  AW handshake
awaddr_i  in  ADDR_W  write address
wvalid_i/wready_o  in/out  1  W handshake
wdata_i  in  32  write data
wstrb_i  in  4  byte strobes
bvalid_o/bready_i  out/in  1  B handshake
bresp_o  out  2  write response
arvalid_i/arready_o  in/out  1  AR handshake
araddr_i  in  ADDR_W  read address
rvalid_o/rready_i  out/in  1  R handshake
rdata_o  out  32  read data
rresp_o  out  2  read response
sof_i  in  1  start-of-frame pulse from the video pipeline
coef_o  out  COEF_CNT*COEF_W  active bank; entry k at [k*COEF_W +: COEF_W]
coef_upd_o  out  1  one-cycle pulse after each commit

Behaviour:
- Reset is asynchronous, active-high (rst_i); clock is clk_i.
- Reset values: all outputs, shadow bank, active bank, SEL, CTRL, counters = 0; awready_o = wready_o = arready_o = 1.
- Address decode:
  - off = addr - BASE_ADDR; idx = off >> 2; addr[1:0] ignored.
  - idx 0 CTRL (RW): bit0 AUTO_INC; bit1 COMMIT, write-1 requests a commit, reads as commit_pending.
  - idx 1 SEL (RW): [SW-1:0], SW = clog2(COEF_CNT).
  - idx 2 COEF (RW): accesses shadow[SEL], byte-strobed, only bits < COEF_W stored.
  - idx 3 STATUS (RO): bit0 commit_pending; [15:8] COEF_CNT; [23:16] commit_cnt (8-bit, wraps 255->0).
  - idx 4 ACTIVE (RO): active[SEL].
  - Any other idx, including off < 0 after wrap, is unmapped.
- Write channel:
  - AW and W are accepted independently into aw_held/w_held; awready_o = !aw_held, wready_o = !w_held.
  - Write executes in the cycle where aw_held && w_held && !bvalid_o.
  - Same edge: held flags clear and bvalid_o sets. AW+W together at edge T gives bvalid_o high after edge T+1.
  - bvalid_o holds until bready_i; a new write cannot execute while bvalid_o is high.
  - bresp_o = 2'b10 (SLVERR), write dropped, for: unmapped address; STATUS/ACTIVE write; COEF write with SEL >= COEF_CNT. Otherwise OKAY.
- Read channel:
  - arready_o = !rvalid_o. Handshake at edge T gives rvalid_o/rdata_o/rresp_o valid after T, held until rready_i.
  - Unmapped address, or COEF/ACTIVE with SEL >= COEF_CNT: rdata_o = 0, rresp_o = SLVERR.
  - rdata_o returns to 0 after the R handshake.
- AUTO_INC: after each successful COEF write, SEL <= (SEL == COEF_CNT-1) ? 0 : SEL+1. SEL is not changed by reads.
- Commit:
  - A CTRL write with wstrb[0] && wdata[1] sets commit_pending.
  - COMMIT_ON_SOF=1: the first cycle with sof_i && commit_pending copies shadow to active, clears pending, increments commit_cnt; coef_upd_o pulses on the next cycle.
  - A request arriving in the same cycle as sof_i sets pending only; that commit lands on the following sof_i.
  - sof_i without pending: no effect.
  - COMMIT_ON_SOF=0: commit happens the cycle after pending sets; sof_i is ignored.
  - A COEF write in the same cycle as a commit: active takes the pre-write shadow value; the shadow takes the new value.
  - Repeated COMMIT writes while pending: no extra effect.
- Reset mid-transaction drops held AW/W and pending commit; no response is issued.

Test Plan:
- COEF_CNT=12: AUTO_INC=1, SEL=0, 12 COEF writes 0x100+k, commit, sof_i pulse -> coef_o entry k = 0x100+k, coef_upd_o one pulse, STATUS = 0x0001_0C00.
- SEL=3, COEF write 0xAABBCCDD with wstrb 4'b0101 over 0x11111111 -> shadow[3] = 0x11BB11DD. ACTIVE read is unchanged until commit.
- AW at cycle 0, W at cycle 5 -> awready_o low cycles 1..5, bvalid_o after cycle 6. bready_i held low 4 cycles: bvalid_o stays high and a second AW stalls in aw_held.
- Write to off 0x40 -> bresp SLVERR. Read 0x40 -> rdata 0, SLVERR. SEL=12, COEF read -> SLVERR. STATUS write -> SLVERR, STATUS unchanged.
- COMMIT request in the same cycle as sof_i -> no update. Next sof_i -> update, commit_cnt 1. 256 commits -> commit_cnt 0.
- COMMIT_ON_SOF=0: COMMIT write -> coef_o updated one cycle after pending sets, no sof_i needed. rst_i asserted with pending set -> pending 0, coef_o 0.
